data_access_unit: RTL

- M-stage memory sequencer; the producer of BusyDA, which the hazard unit consumes to stall F/D/E/M/W.
- Scalar accesses pass straight to the single-word data memory port.
- Vector (128-bit) loads and stores are split into LANES word accesses.
- BusyDA holds the pipeline frozen until the vector transfer completes.

---
 rtl/da_pkg.sv | 33 +++
 rtl/data_access_unit_vec_lane_buffer.sv | 44 ++++
 rtl/data_access_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared types and constants for the M-stage data access unit.
// Lane geometry and the sequencer state encoding live here.
package da_pkg;

    localparam int LANE_W     = 32;
    localparam int LANES      = 4;
    localparam int ADDR_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int VEC_W      = LANE_W * LANES;
    localparam int LIDX_W     = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST,
        DONE
    } da_state_t;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LIDX_W-1:0] idx
    );
        return base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(
        input logic [VEC_W-1:0]  vec,
        input logic [LIDX_W-1:0] idx
    );
        return vec[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/data_access_unit_vec_lane_buffer.sv
// Vector load assembly buffer: per-lane capture, committed to the
// output register only when the final lane lands.
module vec_lane_buffer
    import da_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [LIDX_W-1:0]     i_idx,
    input  logic [LANE_W-1:0]     i_wdata,
    input  logic                  i_commit,
    output logic [VEC_W-1:0]      o_vec
);

    logic [LANES-1:0][LANE_W-1:0] r_lanes;
    logic [LANES-1:0][LANE_W-1:0] w_lanes;
    logic [VEC_W-1:0]             r_vec;

    always_comb begin
        w_lanes = r_lanes;
        if (i_we) begin
            w_lanes[i_idx] = i_wdata;
        end
    end

    // The visible vector only changes on commit, so a partly filled
    // load never leaks onto ReadDataVM.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_lanes <= '0;
            r_vec   <= '0;
        end else begin
            if (i_we) begin
                r_lanes <= w_lanes;
            end
            if (i_commit) begin
                r_vec <= w_lanes;
            end
        end
    end

    assign o_vec = r_vec;

endmodule

// File: rtl/data_access_unit.sv
// M-stage memory sequencer: scalar pass-through, vector split into lanes.
// Optional stall-cycle counter enabled by DA_PERF_CNT_EN.
module data_access_unit
    import da_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic                  VecM,
    input  logic [ADDR_W-1:0]     AddrM,
    input  logic [LANE_W-1:0]     WriteDataM,
    input  logic [VEC_W-1:0]      WriteDataVM,
    input  logic [LANE_W-1:0]     mem_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [LANE_W-1:0]     mem_wdata,
    output logic [LANE_W-1:0]     ReadDataM,
    output logic [VEC_W-1:0]      ReadDataVM,
    output logic                  BusyDA,
    output logic [31:0]           BusyCycles
);

    da_state_t           r_state;
    da_state_t           w_next;
    logic [LIDX_W-1:0]   r_idx;
    logic [LIDX_W-1:0]   w_idx_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [VEC_W-1:0]    r_wdv;
    logic                r_store;

    logic                w_vec_req;
    logic                w_latch;
    logic                w_busy;
    logic                w_lane_we;
    logic [LIDX_W-1:0]   w_lane_idx;
    logic                w_commit;

    assign w_vec_req = MemReqM & VecM;

    always_comb begin
        w_next     = r_state;
        w_idx_nxt  = r_idx;
        w_latch    = 1'b0;
        w_busy     = 1'b0;
        w_lane_we  = 1'b0;
        w_lane_idx = r_idx - LIDX_W'(1);
        w_commit   = 1'b0;
        mem_addr   = AddrM;
        mem_we     = MemReqM & MemWriteM;
        mem_wdata  = WriteDataM;

        unique case (r_state)
            IDLE: begin
                if (w_vec_req) begin
                    w_latch   = 1'b1;
                    w_busy    = 1'b1;
                    w_idx_nxt = LIDX_W'(1);
                    mem_addr  = {AddrM[ADDR_W-1:2], 2'b00};
                    mem_we    = MemWriteM;
                    mem_wdata = WriteDataVM[LANE_W-1:0];
                    if (MemWriteM && (LANES == 2)) begin
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                w_busy    = 1'b1;
                w_idx_nxt = r_idx + LIDX_W'(1);
                mem_addr  = word_addr(r_base, r_idx);
                mem_we    = r_store;
                mem_wdata = lane_of(r_wdv, r_idx);
                w_lane_we = ~r_store;
                if (r_store && (r_idx == LIDX_W'(LANES - 2))) begin
                    w_next = DONE;
                end else if (!r_store &&
                             (r_idx == LIDX_W'(LANES - 1))) begin
                    w_next = LAST;
                end
            end
            LAST: begin
                w_busy     = 1'b1;
                mem_addr   = r_base;
                mem_we     = 1'b0;
                w_lane_we  = 1'b1;
                w_lane_idx = LIDX_W'(LANES - 1);
                w_commit   = 1'b1;
                w_next     = DONE;
            end
            DONE: begin
                // Last store word goes out here; a load issues nothing.
                mem_addr  = word_addr(r_base, r_idx);
                mem_we    = r_store;
                mem_wdata = lane_of(r_wdv, r_idx);
                w_next    = IDLE;
            end
        endcase

        if (rst) begin
            mem_we    = 1'b0;
            w_busy    = 1'b0;
            w_lane_we = 1'b0;
            w_commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_wdv   <= '0;
            r_store <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nxt;
            if (w_latch) begin
                r_base  <= {AddrM[ADDR_W-1:2], 2'b00};
                r_wdv   <= WriteDataVM;
                r_store <= MemWriteM;
            end
        end
    end

    vec_lane_buffer u_buf (
        .clk      (clk),
        .i_clr    (rst),
        .i_we     (w_lane_we),
        .i_idx    (w_lane_idx),
        .i_wdata  (mem_rdata),
        .i_commit (w_commit),
        .o_vec    (ReadDataVM)
    );

    assign BusyDA    = w_busy;
    assign ReadDataM = mem_rdata;

`ifdef DA_PERF_CNT_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cycles <= '0;
        end else if (w_busy && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign BusyCycles = r_busy_cycles;
`else
    assign BusyCycles = 32'd0;
`endif

endmodule
